gpr_port_arbiter: RTL and testbench
===================================

// Module: gpr_port_arbiter
// PURPOSE
//  Shares the single write bus and read enables of the X/Y/accumulator register file among NUM_REQ requesters
//  (e.g. control unit, ALU writeback, load unit). Each transaction is one read or one write of one register.
//  Uses round-robin arbitration, a req/ack handshake and a 3-state sequencer. Sits between the requesters and the register file.
// PARAMETERS
//  NUM_REQ  3   number of requesters (2..8); index 0 has first priority after reset
//  DW       16  register/data width
// PORTS
//  clk                    in   1           clock, rising edge
//  rst                    in   1           asynchronous, active-low reset
//  req                    in   NUM_REQ     per-requester transaction request
//  req_we                 in   NUM_REQ     1=write, 0=read
//  req_sel                in   2*NUM_REQ   target register: 0=X, 1=Y, 2=ACC, 3=invalid
//  req_wdata              in   DW*NUM_REQ  write data, slice i = requester i
//  req_lock               in   NUM_REQ     hold grant for back-to-back access (GPR_LOCK_EN only)
//  gnt                    out  NUM_REQ     one-hot, owner of current transaction
//  ack                    out  NUM_REQ     one-cycle completion pulse to owner
//  rdata                  out  DW          read result, valid while ack is high on a read
//  err                    out  1           with ack: sel==3; write dropped, rdata=0
//  busy                   out  1           state != IDLE
//  data_in                out  DW          register-file write data
//  reg_write_x/_y/_accumulator  out 1 each  register-file write strobes
//  reg_read_x/_y/_accumulator   out 1 each  register-file read enables
//  data_out_x/_y/_accumulator   in  DW each register-file read data (combinational)
// BEHAVIOUR
//  - Reset: state=IDLE; gnt, ack, rdata, err, busy, data_in and all strobes/enables = 0; rr pointer = NUM_REQ-1.
//  - FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if |req, winner = first requester set, scanning from ptr+1 upward with wrap.
//    Latch the winner's index, we, sel and wdata; ptr <= winner; go to ACCESS. Otherwise stay in IDLE.
//  - ACCESS (1 cycle): gnt[owner]=1; data_in=latched wdata.
//    Write: the one strobe selected by sel = 1. Read: the one enable selected by sel = 1.
//    On a read, rdata register captures the selected data_out_* at the clock edge. sel==3 drives no strobe/enable.
//  - DONE (1 cycle): gnt[owner]=1; ack[owner]=1; rdata held (0 for writes and sel==3); err=(sel==3).
//  - Latency: req seen in IDLE at edge N -> strobe during N+1 -> ack during N+2. One transaction per 3 cycles.
//  - All outputs to the register file are decoded only from registered state and latched fields.
//    No combinational path from req* to strobes.
//  - Requester inputs are sampled only at latch time; dropping req after the latch does not abort the transaction.
//  - Winner's req must be low in the cycle after its ack, or it is treated as a new request.
//  - Simultaneous requests: exactly one gnt; others wait; every persistent requester is served within NUM_REQ transactions.
//  - rdata/err keep their value outside DONE; they are meaningful only with ack.
//  - Asynchronous reset mid-transaction: immediate return to reset values; a pending write is dropped if the strobe has not yet been clocked.
// CONFIGURATION
//  GPR_LOCK_EN defined: in DONE, if req_lock[owner] and req[owner] are high, latch the owner's new fields.
//    Go DONE -> ACCESS directly, ptr unchanged. Yields 1 transaction per 2 cycles for the locked owner.
//  GPR_LOCK_EN undefined: the req_lock port exists but is ignored; DONE always returns to IDLE.
// STRUCTURE
//  - Shared include gpr_defs.vh: localparams GPR_SEL_X=2'd0, GPR_SEL_Y=2'd1, GPR_SEL_ACC=2'd2, GPR_SEL_BAD=2'd3.
//    Also the state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
//  - Sub-module rr_priority_pick: combinational, (req, ptr) -> one-hot winner + index.
//    Parameterised by NUM_REQ and reused by other shared-resource arbiters.
//  - Top: FSM, latch registers, sel decode, rdata mux/register.
// TESTING
//  1. Reset: rst=0 mid-run -> all outputs 0 immediately; after release, req=3'b111 -> first gnt=3'b001.
//  2. Write/read: req0 writes X=16'hA5A5 -> reg_write_x for 1 cycle, ack0 2 cycles after the latch edge.
//     Then req0 reads X -> rdata=16'hA5A5 with ack0, err=0.
//  3. Round-robin: req=3'b111 held -> gnt order 0,1,2,0; req=3'b101 -> gnt order 0,2,0,2.
//  4. Bad select: req1 sel=3, we=1, wdata=16'hBEEF -> no strobe, ack1 with err=1, rdata=0; registers unchanged.
//  5. Reset mid-op: rst low during ACCESS of an ACC write of 16'h1234 -> ACC reads back 0; FSM in IDLE.
//  6. GPR_LOCK_EN: req2 locked, 3 writes -> acks 2 cycles apart, req0 waits until lock drops.
//     Without the macro -> acks 3 cycles apart and req0 is interleaved.

Source files
------------

// File: rtl/gpr_port_arbiter_pkg.sv
// Shared definitions for the GPR port arbiter: register select codes and sequencer states.
package gpr_port_arbiter_pkg;

    localparam logic [1:0] GPR_SEL_X   = 2'd0;
    localparam logic [1:0] GPR_SEL_Y   = 2'd1;
    localparam logic [1:0] GPR_SEL_ACC = 2'd2;
    localparam logic [1:0] GPR_SEL_BAD = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } gpr_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1 with wrap.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      idx
);

    int unsigned cand;

    // Scan farthest-first so the candidate nearest ptr+1 is the last one assigned.
    always_comb begin
        winner = '0;
        idx    = '0;
        cand   = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/gpr_port_arbiter.sv
// Round-robin arbiter sharing the X/Y/ACC register-file ports among NUM_REQ requesters.
// Optional macro GPR_LOCK_EN: a locked owner chains DONE -> ACCESS for back-to-back access.
module gpr_port_arbiter
    import gpr_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [2*NUM_REQ-1:0]  req_sel,
    input  logic [DW*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_lock,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  err,
    output logic                  busy,
    output logic [DW-1:0]         data_in,
    output logic                  reg_write_x,
    output logic                  reg_write_y,
    output logic                  reg_write_accumulator,
    output logic                  reg_read_x,
    output logic                  reg_read_y,
    output logic                  reg_read_accumulator,
    input  logic [DW-1:0]         data_out_x,
    input  logic [DW-1:0]         data_out_y,
    input  logic [DW-1:0]         data_out_accumulator
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    gpr_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               do_latch;
    logic [IW-1:0]      lat_idx;
    logic [DW-1:0]      rd_mux;

`ifndef GPR_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        unique case (sel_q)
            GPR_SEL_X:   rd_mux = data_out_x;
            GPR_SEL_Y:   rd_mux = data_out_y;
            GPR_SEL_ACC: rd_mux = data_out_accumulator;
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        do_latch = 1'b0;
        lat_idx  = pick_idx;
        unique case (state_q)
            StIdle: begin
                if (|pick_onehot) begin
                    do_latch = 1'b1;
                    ptr_d    = pick_idx;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                state_d = StDone;
                err_d   = (sel_q == GPR_SEL_BAD);
                rdata_d = we_q ? '0 : rd_mux;
            end
            StDone: begin
                state_d = StIdle;
`ifdef GPR_LOCK_EN
                if (req_lock[owner_q] && req[owner_q]) begin
                    do_latch = 1'b1;
                    lat_idx  = owner_q;
                    state_d  = StAccess;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        // Requester fields are sampled only here; later changes cannot disturb a transaction.
        if (do_latch) begin
            owner_d = lat_idx;
            we_d    = req_we[lat_idx];
            sel_d   = req_sel[32'(lat_idx)*2 +: 2];
            wdata_d = req_wdata[32'(lat_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            we_q    <= 1'b0;
            sel_q   <= GPR_SEL_X;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Register-file side decoded purely from registered state.
    always_comb begin
        gnt                   = '0;
        ack                   = '0;
        data_in               = '0;
        reg_write_x           = 1'b0;
        reg_write_y           = 1'b0;
        reg_write_accumulator = 1'b0;
        reg_read_x            = 1'b0;
        reg_read_y            = 1'b0;
        reg_read_accumulator  = 1'b0;
        if (state_q != StIdle) gnt[owner_q] = 1'b1;
        if (state_q == StDone) ack[owner_q] = 1'b1;
        if (state_q == StAccess) begin
            data_in = wdata_q;
            reg_write_x           = we_q  && (sel_q == GPR_SEL_X);
            reg_write_y           = we_q  && (sel_q == GPR_SEL_Y);
            reg_write_accumulator = we_q  && (sel_q == GPR_SEL_ACC);
            reg_read_x            = !we_q && (sel_q == GPR_SEL_X);
            reg_read_y            = !we_q && (sel_q == GPR_SEL_Y);
            reg_read_accumulator  = !we_q && (sel_q == GPR_SEL_ACC);
        end
    end

    assign busy  = (state_q != StIdle);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// Self-checking bench for gpr_port_arbiter: register-file model, round-robin reference, random rounds.
module tb_gpr_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DW      = 16;
`ifdef GPR_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    req = '0, req_we = '0, req_lock = '0;
    logic [2*NUM_REQ-1:0]  req_sel = '0;
    logic [DW*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    gnt, ack;
    logic [DW-1:0]         rdata, data_in;
    logic                  err, busy;
    logic                  reg_write_x, reg_write_y, reg_write_accumulator;
    logic                  reg_read_x, reg_read_y, reg_read_accumulator;
    logic [DW-1:0]         rf_x = '0, rf_y = '0, rf_acc = '0;

    int n_assert = 0;
    int n_fail   = 0;

    int             want [NUM_REQ];
    bit             lk   [NUM_REQ];
    logic           f_we [NUM_REQ];
    logic [1:0]     f_sel[NUM_REQ];
    logic [DW-1:0]  f_wd [NUM_REQ];
    logic [DW-1:0]  m_reg[3];
    int             m_ptr;

    gpr_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req                   (req),
        .req_we                (req_we),
        .req_sel               (req_sel),
        .req_wdata             (req_wdata),
        .req_lock              (req_lock),
        .gnt                   (gnt),
        .ack                   (ack),
        .rdata                 (rdata),
        .err                   (err),
        .busy                  (busy),
        .data_in               (data_in),
        .reg_write_x           (reg_write_x),
        .reg_write_y           (reg_write_y),
        .reg_write_accumulator (reg_write_accumulator),
        .reg_read_x            (reg_read_x),
        .reg_read_y            (reg_read_y),
        .reg_read_accumulator  (reg_read_accumulator),
        .data_out_x            (rf_x),
        .data_out_y            (rf_y),
        .data_out_accumulator  (rf_acc)
    );

    always #5 clk = ~clk;

    // Register file: captures data_in on its write strobes, never reset.
    always @(posedge clk) begin
        if (reg_write_x)           rf_x   <= data_in;
        if (reg_write_y)           rf_y   <= data_in;
        if (reg_write_accumulator) rf_acc <= data_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [45:0] all_outputs();
        return {gnt, ack, rdata, err, busy, data_in, reg_write_x, reg_write_y,
                reg_write_accumulator, reg_read_x, reg_read_y, reg_read_accumulator};
    endfunction

    function automatic logic [5:0] exp_strobes(input logic we, input logic [1:0] sel);
        logic [5:0] v = '0;
        if (sel != 2'd3) begin
            if (we) v[5 - sel] = 1'b1;
            else    v[2 - sel] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin rule: nearest requester above the last winner, wrapping.
    function automatic int rr_next(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic drive_fields(input int i, input logic we, input logic [1:0] sel,
                                input logic [DW-1:0] wd);
        f_we[i] = we; f_sel[i] = sel; f_wd[i] = wd;
        req_we[i] = we;
        req_sel[2*i +: 2] = sel;
        req_wdata[DW*i +: DW] = wd;
    endtask

    task automatic rand_fields(input int i);
        logic [1:0] s;
        s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        drive_fields(i, 1'($urandom_range(0, 1)), s, 16'($urandom));
    endtask

    // Serve every outstanding transaction in want[], checking each against the model.
    task automatic run_round();
        int total = 0, served = 0, owner = -1, t = 0, last_ack = -1, first_acc = -1;
        bit chain = 1'b0;
        logic [DW-1:0] exp_rd;
        for (int i = 0; i < NUM_REQ; i++) begin
            total += want[i];
            req[i] = (want[i] > 0);
            req_lock[i] = lk[i];
        end
        while (served < total && t < 12 * total + 10) begin
            @(negedge clk);
            t++;
            if (busy && ack == '0) begin
                if (!chain) owner = rr_next(req, m_ptr);
                if (first_acc < 0) first_acc = t;
                if (owner < 0) begin
                    check("spurious_busy", 1, 0);
                end else begin
                    check("gnt_access", gnt, 1 << owner);
                    check("strobes", {reg_write_x, reg_write_y, reg_write_accumulator,
                          reg_read_x, reg_read_y, reg_read_accumulator},
                          exp_strobes(f_we[owner], f_sel[owner]));
                    if (f_we[owner]) check("data_in", data_in, f_wd[owner]);
                end
            end else if (ack != '0) begin
                if (owner < 0) begin
                    check("spurious_ack", 1, 0);
                    owner = 0;
                end
                exp_rd = (!f_we[owner] && f_sel[owner] != 2'd3) ? m_reg[f_sel[owner]] : '0;
                check("ack", ack, 1 << owner);
                check("gnt_done", gnt, 1 << owner);
                check("err", err, f_sel[owner] == 2'd3);
                check("rdata", rdata, exp_rd);
                if (last_ack >= 0) check("ack_gap", t - last_ack, chain ? 2 : 3);
                last_ack = t;
                if (f_we[owner] && f_sel[owner] != 2'd3) m_reg[f_sel[owner]] = f_wd[owner];
                m_ptr = owner;
                served++;
                want[owner]--;
                chain = LOCK && lk[owner] && want[owner] > 0;
                if (want[owner] > 0) rand_fields(owner);
                else req[owner] = 1'b0;
            end
        end
        if (served < total) check("round_timeout", served, total);
        check("first_latency", first_acc, 1);
        req = '0;
        req_lock = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 0;
            lk[i] = 1'b0;
        end
        @(negedge clk);
        check("rf_x", rf_x, m_reg[0]);
        check("rf_y", rf_y, m_reg[1]);
        check("rf_acc", rf_acc, m_reg[2]);
    endtask

    initial begin
        int w;
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 0; lk[i] = 1'b0; f_we[i] = 1'b0; f_sel[i] = 2'd0; f_wd[i] = '0;
        end
        for (int i = 0; i < 3; i++) m_reg[i] = '0;
        m_ptr = NUM_REQ - 1;

        // Reset values
        #1;
        check("reset_outputs", all_outputs(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset during ACCESS of an ACC write drops the write
        drive_fields(0, 1'b1, 2'd2, 16'h1234);
        req = 3'b001;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(busy && ack == '0) && w < 5);
        check("acc_write_strobe", reg_write_accumulator, 1'b1);
        #2 rst = 1'b0;
        #1 check("midop_reset_outputs", all_outputs(), '0);
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        m_ptr = NUM_REQ - 1;
        check("acc_after_reset", rf_acc, 16'h0000);

        // After reset all three request; requester 0 wins first
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 1;
            rand_fields(i);
        end
        run_round();

        // Write X then read it back
        drive_fields(0, 1'b1, 2'd0, 16'hA5A5);
        want[0] = 1;
        run_round();
        drive_fields(0, 1'b0, 2'd0, 16'h0000);
        want[0] = 1;
        run_round();
        check("x_readback", rf_x, 16'hA5A5);

        // Held requests rotate 0,1,2,0,... and 0,2,0,2
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 2;
            rand_fields(i);
        end
        run_round();
        want[0] = 2; want[2] = 2;
        rand_fields(0);
        rand_fields(2);
        run_round();

        // Invalid select: no strobe, err with ack, rdata 0
        drive_fields(1, 1'b1, 2'd3, 16'hBEEF);
        want[1] = 1;
        run_round();

        // Locked owner: back-to-back with the macro, interleaved without
        drive_fields(1, 1'b0, 2'd1, 16'h0);
        want[1] = 1;
        run_round();
        drive_fields(2, 1'b1, 2'd1, 16'h1111);
        drive_fields(0, 1'b1, 2'd0, 16'h2222);
        want[2] = 3; lk[2] = 1'b1;
        want[0] = 1;
        run_round();

        // Random rounds
        repeat (20) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                want[i] = $urandom_range(0, 2);
                rand_fields(i);
            end
            if (want[0] + want[1] + want[2] == 0) want[$urandom_range(0, NUM_REQ-1)] = 1;
            run_round();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
